// File: rtl/systolic_ctrl_if.sv
// Job request / array control bundle between a job issuer and systolic_ctrl.
//   master : issuer side  (drives start, mode_cfg, k_len; observes the rest)
//   slave  : controller side (drives op_sig, wgt_row, feed_*, drain_*, busy, done)
// Optional: SYSTOLIC_CTRL_PERF_EN adds perf_cycles[31:0] (controller-driven).
interface systolic_ctrl_if #(
  parameter int unsigned ARRAY_DIM = 8,
  parameter int unsigned K_WIDTH   = 16
);
  localparam int unsigned ROW_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;

  logic                   start;
  logic                   mode_cfg;
  logic [K_WIDTH-1:0]     k_len;
  logic [3*ARRAY_DIM-1:0] op_sig;
  logic [ROW_W-1:0]       wgt_row;
  logic                   feed_en;
  logic [K_WIDTH-1:0]     feed_idx;
  logic                   drain_valid;
  logic [ROW_W-1:0]       drain_row;
  logic                   busy;
  logic                   done;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]            perf_cycles;

  modport master (
    output start, mode_cfg, k_len,
    input  op_sig, wgt_row, feed_en, feed_idx, drain_valid, drain_row, busy, done,
    input  perf_cycles
  );
  modport slave (
    input  start, mode_cfg, k_len,
    output op_sig, wgt_row, feed_en, feed_idx, drain_valid, drain_row, busy, done,
    output perf_cycles
  );
`else
  modport master (
    output start, mode_cfg, k_len,
    input  op_sig, wgt_row, feed_en, feed_idx, drain_valid, drain_row, busy, done
  );
  modport slave (
    input  start, mode_cfg, k_len,
    output op_sig, wgt_row, feed_en, feed_idx, drain_valid, drain_row, busy, done
  );
`endif
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an ARRAY_DIM x ARRAY_DIM systolic PE grid: weight preload (WS),
// compute with skew fill/flush, output-stationary drain (OS), completion pulse.
// Ports: clk, reset (async, active-high), bus (systolic_ctrl_if.slave):
//   start/mode_cfg/k_len in; op_sig (per-row {mode,os_drain,wgt_load}), wgt_row,
//   feed_en/feed_idx, drain_valid/drain_row, busy, done out. All outputs registered.
// Optional: define SYSTOLIC_CTRL_PERF_EN for the perf_cycles busy-cycle counter.
module systolic_ctrl #(
  parameter int unsigned ARRAY_DIM = 8,
  parameter int unsigned K_WIDTH   = 16
) (
  input logic            clk,
  input logic            reset,
  systolic_ctrl_if.slave bus
);
  localparam int unsigned ROW_W = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam int unsigned CNT_W = K_WIDTH + 1;
  localparam int unsigned OP_W  = 3 * ARRAY_DIM;
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ARRAY_DIM - 1);
  localparam logic [CNT_W-1:0] SKEW     = CNT_W'(2 * (ARRAY_DIM - 1));

  typedef enum logic [2:0] {S_IDLE, S_LOAD_WGT, S_COMPUTE, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               mode_q, mode_nxt;
  logic [K_WIDTH-1:0] k_q, k_nxt;
  logic [CNT_W-1:0]   compute_last;

  logic [OP_W-1:0]    op_q, op_d;
  logic [ROW_W-1:0]   wgt_row_q, wgt_row_d;
  logic               feed_en_q, feed_en_d;
  logic [K_WIDTH-1:0] feed_idx_q, feed_idx_d;
  logic               drain_valid_q, drain_valid_d;
  logic [ROW_W-1:0]   drain_row_q, drain_row_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Last COMPUTE cycle index; k_len > 0 whenever COMPUTE is entered.
  assign compute_last = {1'b0, k_q} + SKEW - CNT_W'(1);

  // State register with per-state cycle counter and latched job parameters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      mode_q  <= mode_nxt;
      k_q     <= k_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q + CNT_W'(1);
    mode_nxt  = mode_q;
    k_nxt     = k_q;
    case (state_q)
      S_IDLE: begin
        cnt_nxt = '0;
        if (bus.start) begin
          mode_nxt = bus.mode_cfg;
          k_nxt    = bus.k_len;
          if (bus.k_len == '0)    state_nxt = S_DONE;
          else if (!bus.mode_cfg) state_nxt = S_LOAD_WGT;
          else                    state_nxt = S_COMPUTE;
        end
      end
      S_LOAD_WGT: if (cnt_q == ROW_LAST) begin
        state_nxt = S_COMPUTE;
        cnt_nxt   = '0;
      end
      S_COMPUTE: if (cnt_q == compute_last) begin
        state_nxt = mode_q ? S_DRAIN : S_DONE;
        cnt_nxt   = '0;
      end
      S_DRAIN: if (cnt_q == ROW_LAST) begin
        state_nxt = S_DONE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with it.
  always_comb begin
    op_d          = '0;
    wgt_row_d     = '0;
    feed_en_d     = 1'b0;
    feed_idx_d    = feed_idx_q;
    drain_valid_d = 1'b0;
    drain_row_d   = '0;
    busy_d        = (state_nxt != S_IDLE);
    done_d        = (state_nxt == S_DONE);
    case (state_nxt)
      S_LOAD_WGT: begin
        wgt_row_d = cnt_nxt[ROW_W-1:0];
        for (int unsigned r = 0; r < ARRAY_DIM; r++)
          if (CNT_W'(r) == cnt_nxt) op_d[3*r +: 3] = 3'b001;
      end
      S_COMPUTE: begin
        for (int unsigned r = 0; r < ARRAY_DIM; r++) op_d[3*r +: 3] = {mode_nxt, 2'b00};
        if (cnt_nxt < {1'b0, k_nxt}) begin
          feed_en_d  = 1'b1;
          feed_idx_d = cnt_nxt[K_WIDTH-1:0];
        end
      end
      S_DRAIN: begin
        for (int unsigned r = 0; r < ARRAY_DIM; r++) op_d[3*r +: 3] = 3'b110;
        drain_valid_d = 1'b1;
        // Bottom row leaves first.
        drain_row_d   = ROW_W'(ARRAY_DIM - 1) - cnt_nxt[ROW_W-1:0];
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q          <= '0;
      wgt_row_q     <= '0;
      feed_en_q     <= 1'b0;
      feed_idx_q    <= '0;
      drain_valid_q <= 1'b0;
      drain_row_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      op_q          <= op_d;
      wgt_row_q     <= wgt_row_d;
      feed_en_q     <= feed_en_d;
      feed_idx_q    <= feed_idx_d;
      drain_valid_q <= drain_valid_d;
      drain_row_q   <= drain_row_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.op_sig      = op_q;
  assign bus.wgt_row     = wgt_row_q;
  assign bus.feed_en     = feed_en_q;
  assign bus.feed_idx    = feed_idx_q;
  assign bus.drain_valid = drain_valid_q;
  assign bus.drain_row   = drain_row_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Restart at 1 on launch (first busy cycle), saturating count while busy, hold otherwise.
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE && state_nxt != S_IDLE) perf_d = 32'd1;
    else if (state_nxt != S_IDLE && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign bus.perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with ARRAY_DIM=4, K_WIDTH=16.
module tb_systolic_ctrl;
  localparam int D = 4;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  systolic_ctrl_if #(.ARRAY_DIM(D), .K_WIDTH(16)) bus ();

  systolic_ctrl #(.ARRAY_DIM(D), .K_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".op_sig"},      64'(bus.op_sig),      64'd0);
    check({tag, ".wgt_row"},     64'(bus.wgt_row),     64'd0);
    check({tag, ".feed_en"},     64'(bus.feed_en),     64'd0);
    check({tag, ".feed_idx"},    64'(bus.feed_idx),    64'd0);
    check({tag, ".drain_valid"}, 64'(bus.drain_valid), 64'd0);
    check({tag, ".drain_row"},   64'(bus.drain_row),   64'd0);
    check({tag, ".busy"},        64'(bus.busy),        64'd0);
    check({tag, ".done"},        64'(bus.done),        64'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check({tag, ".perf"},        64'(bus.perf_cycles), 64'd0);
`endif
  endtask

  // Called at a negedge; launches a job and checks every busy cycle plus the IDLE after it.
  task automatic run_job(input logic mode, input logic [15:0] k, input int exp_len,
                         input bit hold, input int pulse_at);
    int          ki, c_len, j;
    logic [11:0] one, exp_op;
    logic [1:0]  exp_wr, exp_dr;
    logic        exp_fe, exp_dv, chk_fi;
    logic [15:0] exp_fi;
    string       t;
    one   = 12'd1;
    ki    = int'(k);
    c_len = ki + 2 * (D - 1);
    bus.mode_cfg = mode;
    bus.k_len    = k;
    bus.start    = 1'b1;
    for (int n = 1; n <= exp_len; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.start    = hold;
        bus.mode_cfg = ~mode;
        bus.k_len    = k + 16'd7;
      end
      if (n == pulse_at) bus.start = 1'b1;
      else if (n == pulse_at + 1) bus.start = hold;
      exp_op = '0; exp_wr = '0; exp_fe = 1'b0; exp_dv = 1'b0; exp_dr = '0;
      chk_fi = 1'b0; exp_fi = '0;
      if (ki == 0) begin
      end else if (!mode && n <= D) begin
        exp_op = one << (3 * (n - 1));
        exp_wr = 2'(n - 1);
      end else begin
        j = mode ? n - 1 : n - 1 - D;
        if (j < c_len) begin
          exp_op = mode ? 12'h924 : 12'h000;
          exp_fe = (j < ki);
          chk_fi = 1'b1;
          exp_fi = (j < ki) ? 16'(j) : 16'(ki - 1);
        end else if (mode && j < c_len + D) begin
          exp_op = 12'hDB6;
          exp_dv = 1'b1;
          exp_dr = 2'(D - 1 - (j - c_len));
        end
      end
      t = $sformatf("m%0d_k%0d_c%0d", mode, ki, n);
      check({t, ".busy"},        64'(bus.busy),        64'd1);
      check({t, ".done"},        64'(bus.done),        64'(n == exp_len));
      check({t, ".op_sig"},      64'(bus.op_sig),      64'(exp_op));
      check({t, ".wgt_row"},     64'(bus.wgt_row),     64'(exp_wr));
      check({t, ".feed_en"},     64'(bus.feed_en),     64'(exp_fe));
      if (chk_fi) check({t, ".feed_idx"}, 64'(bus.feed_idx), 64'(exp_fi));
      check({t, ".drain_valid"}, 64'(bus.drain_valid), 64'(exp_dv));
      check({t, ".drain_row"},   64'(bus.drain_row),   64'(exp_dr));
`ifdef SYSTOLIC_CTRL_PERF_EN
      if (n == 1) check({t, ".perf_start"}, 64'(bus.perf_cycles), 64'd1);
`endif
    end
    @(negedge clk);
    t = $sformatf("m%0d_k%0d_idle", mode, ki);
    check({t, ".busy"}, 64'(bus.busy), 64'd0);
    check({t, ".done"}, 64'(bus.done), 64'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check({t, ".perf_final"}, 64'(bus.perf_cycles), 64'(exp_len));
`endif
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.mode_cfg = 1'b0;
    bus.k_len    = '0;
    #2;
    check_all_zero("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_job(1'b0, 16'd5, 16, 1'b0, 0);   // WS: 4 load + 11 compute + done
    run_job(1'b1, 16'd3, 14, 1'b0, 0);   // OS: 9 compute + 4 drain + done
    run_job(1'b0, 16'd0, 1,  1'b0, 0);   // WS empty job
    run_job(1'b1, 16'd0, 1,  1'b0, 0);   // OS empty job
    run_job(1'b1, 16'd3, 14, 1'b1, 5);   // mid-COMPUTE pulse, start held through done
    run_job(1'b0, 16'd5, 16, 1'b0, 0);   // relaunch exactly one IDLE cycle later

    // Asynchronous reset in the middle of COMPUTE.
    bus.mode_cfg = 1'b1;
    bus.k_len    = 16'd5;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset.busy", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    check_all_zero("held_rst");
    reset = 1'b0;
    run_job(1'b1, 16'd2, 13, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for a square ARRAY_DIM x ARRAY_DIM grid of PEs.
- Drives each PE row's 3-bit operation signal {mode, os_drain, wgt_load}.
- Steps the array through weight preload, compute with skew fill/flush, and output-stationary drain.
- Tells the activation/weight feeders when to advance and which reduction index to present.

Parameters:
- ARRAY_DIM, 8, number of PE rows (equal to columns).
- K_WIDTH, 16, width of the reduction-length field and the feed index.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- mode_cfg  in  1  1 = output-stationary (OS), 0 = weight-stationary (WS); latched at start.
- k_len  in  K_WIDTH  reduction length; latched at start.
- op_sig  out  3*ARRAY_DIM  per-row {mode, os_drain, wgt_load}; row r occupies bits [3r+2:3r].
- wgt_row  out  $clog2(ARRAY_DIM)  row being preloaded (WS LOAD_WGT only, else 0).
- feed_en  out  1  feeders present the next activation/weight vector.
- feed_idx  out  K_WIDTH  reduction index of the current feed.
- drain_valid  out  1  bottom-row OS result valid this cycle.
- drain_row  out  $clog2(ARRAY_DIM)  logical row of the result leaving the bottom.
- busy  out  1  a job is in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered.
- Reset forces state IDLE and every output to 0, including op_sig = 0 for all rows. It acts immediately, in any state.
- States: IDLE, LOAD_WGT, COMPUTE, DRAIN, DONE.
- IDLE:
  - start=1 at edge T latches mode_cfg/k_len; busy=1 from T+1.
  - Next state: k_len==0 -> DONE; else mode_cfg=0 -> LOAD_WGT; else -> COMPUTE.
- LOAD_WGT (WS only):
  - Lasts ARRAY_DIM cycles; cycle i drives wgt_row=i.
  - Row i op_sig=3'b001; all other rows 3'b000.
  - Then -> COMPUTE.
- COMPUTE:
  - Lasts k_len + 2*(ARRAY_DIM-1) cycles; the cycle counter is K_WIDTH+1 bits, so there is no overflow at max k_len.
  - op_sig = 3'b100 on all rows (OS) or 3'b000 (WS).
  - feed_en=1 for the first k_len cycles, feed_idx = 0..k_len-1; afterwards feed_en=0 and feed_idx holds its last value. The remaining cycles flush the skew.
  - Next state: OS -> DRAIN, WS -> DONE.
- DRAIN (OS only):
  - Lasts ARRAY_DIM cycles; op_sig = 3'b110 on all rows.
  - drain_valid=1; drain_row = ARRAY_DIM-1 down to 0, bottom row first.
  - The top-row result_in is tied to zero, so DRAIN also leaves every accumulator at 0 for the next OS job.
  - Then -> DONE.
- DONE:
  - One cycle: done=1, busy=1, op_sig=0. Then -> IDLE.
  - busy drops in the IDLE cycle.
- start while busy is ignored, not queued. IDLE always lasts at least one cycle, so a start held high re-launches one cycle after done.
- mode_cfg and k_len changes after start have no effect on the running job.
- Busy length (cycles with busy=1):
  - WS: ARRAY_DIM + k_len + 2*(ARRAY_DIM-1) + 1.
  - OS: k_len + 2*(ARRAY_DIM-1) + ARRAY_DIM + 1.
  - k_len=0: 1.

Optional Feature:
- Macro: SYSTOLIC_CTRL_PERF_EN.
- When defined:
  - Adds output perf_cycles [31:0], cleared at job start and incremented every busy cycle.
  - Holds the final count (equal to the busy length) from done until the next start.
  - Saturates at 32'hFFFF_FFFF; reset clears it.
- When undefined: the port and counter are absent and all other behaviour is identical.

Test Plan:
- WS, ARRAY_DIM=4, k_len=5:
  - wgt_load one-hot rows 0,1,2,3 on 4 consecutive cycles with wgt_row 0..3.
  - Then 11 COMPUTE cycles with op_sig=0 and feed_en high on the first 5 (feed_idx 0..4).
  - done on busy cycle 16; drain_valid never asserted.
- OS, ARRAY_DIM=4, k_len=3:
  - No wgt_load; 9 COMPUTE cycles with op_sig=3'b100 per row and feed_en on the first 3.
  - 4 DRAIN cycles with op_sig=3'b110 and drain_row 3,2,1,0.
  - done on busy cycle 14.
- k_len=0 in either mode: busy for exactly 1 cycle with done=1; op_sig, feed_en and drain_valid stay 0.
- start pulsed during COMPUTE and held high through done:
  - The mid-job pulse is ignored; the job length is unchanged.
  - A second job begins exactly one IDLE cycle after done.
- reset asserted mid-COMPUTE (not aligned to clk): all outputs 0 before the next edge; after release, a fresh OS job with k_len=2 completes in 13 busy cycles.
- With SYSTOLIC_CTRL_PERF_EN defined: perf_cycles=16 after the WS k_len=5 job and 14 after the OS k_len=3 job; it is cleared by the next start.
